refclk_strobe_gen: RTL and testbench

- Brings the slow external reference clock (nominally 32.768 kHz, on the chip-input refclk pin) into the system clock domain.
- Derives single-cycle timing strobes from it for the rest of the digital clock:
  - 1 Hz timekeeping strobe
  - slow and fast time-set repeat strobes
  - button debounce sample strobe
- Sits between the top-level pin wrapper and the time register, set logic and debouncers. It merges the refclk synchroniser and strobe divider into one block.

---
 rtl/refclk_strobe_gen.sv | 71 +++++++
 tb/tb_refclk_strobe_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/refclk_strobe_gen.sv
// rtl/refclk_strobe_gen.sv - refclk synchroniser and power-of-two timing strobe divider
module refclk_strobe_gen #(
    parameter int COUNT_WIDTH   = 15,
    parameter int SLOW_SET_BITS = 14,
    parameter int FAST_SET_BITS = 11,
    parameter int DEBOUNCE_BITS = 5
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_refclk,
    output logic o_refclk_sync,
    output logic o_1hz_stb,
    output logic o_slow_set_stb,
    output logic o_fast_set_stb,
    output logic o_debounce_stb
);

    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic                   refclk_sync;
    logic [COUNT_WIDTH-1:0] count;
    logic                   stb_1hz;
    logic                   stb_slow;
    logic                   stb_fast;
    logic                   stb_debounce;

    // Low counter bits all-ones on an edge pulse means this edge completes a period.
    logic wrap_1hz;
    logic wrap_slow;
    logic wrap_fast;
    logic wrap_debounce;

    assign wrap_1hz      = &count;
    assign wrap_slow     = &count[SLOW_SET_BITS-1:0];
    assign wrap_fast     = &count[FAST_SET_BITS-1:0];
    assign wrap_debounce = &count[DEBOUNCE_BITS-1:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            prev         <= 1'b0;
            refclk_sync  <= 1'b0;
            count        <= '0;
            stb_1hz      <= 1'b0;
            stb_slow     <= 1'b0;
            stb_fast     <= 1'b0;
            stb_debounce <= 1'b0;
        end else begin
            sync1        <= i_refclk;
            sync2        <= sync1;
            prev         <= sync2;
            refclk_sync  <= sync2 & ~prev;
            if (refclk_sync) begin
                count <= count + 1'b1;
            end
            stb_1hz      <= refclk_sync & wrap_1hz;
            stb_slow     <= refclk_sync & wrap_slow;
            stb_fast     <= refclk_sync & wrap_fast;
            stb_debounce <= refclk_sync & wrap_debounce;
        end
    end

    assign o_refclk_sync  = refclk_sync;
    assign o_1hz_stb      = stb_1hz;
    assign o_slow_set_stb = stb_slow;
    assign o_fast_set_stb = stb_fast;
    assign o_debounce_stb = stb_debounce;

endmodule

// File: tb/tb_refclk_strobe_gen.sv
// tb/tb_refclk_strobe_gen.sv - randomized directed bench for refclk_strobe_gen against an edge-count model
module tb_refclk_strobe_gen;

    localparam int CW   = 8;
    localparam int SL   = 6;
    localparam int FS   = 4;
    localparam int DB   = 2;
    localparam int MAXC = 32768;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic refclk = 1'b0;
    logic o_refclk_sync, o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_debounce_stb;

    always #50 clk = ~clk;

    refclk_strobe_gen #(
        .COUNT_WIDTH  (CW),
        .SLOW_SET_BITS(SL),
        .FAST_SET_BITS(FS),
        .DEBOUNCE_BITS(DB)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_refclk      (refclk),
        .o_refclk_sync (o_refclk_sync),
        .o_1hz_stb     (o_1hz_stb),
        .o_slow_set_stb(o_slow_set_stb),
        .o_fast_set_stb(o_fast_set_stb),
        .o_debounce_stb(o_debounce_stb)
    );

    // Expected {sync, 1hz, slow, fast, debounce} after each posedge, indexed by posedge number.
    logic [4:0] exp_q [MAXC];
    int cyc = 0;
    int n_edges = 0;
    int vectors = 0;
    int miscompares = 0;
    bit last_r = 1'b0;
    bit in_reset = 1'b1;
    int cnt_sync = 0, cnt_1hz = 0, cnt_slow = 0, cnt_fast = 0, cnt_deb = 0;
    int last_sync_cyc = -1;
    int hz_cyc [$];

    function automatic logic [4:0] observed();
        return {o_refclk_sync, o_1hz_stb, o_slow_set_stb, o_fast_set_stb, o_debounce_stb};
    endfunction

    task automatic check_vec(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive refclk, let the model schedule any edge, then compare after the posedge.
    task automatic tick(input logic r);
        logic [4:0] o;
        refclk = r;
        if (!in_reset && r && !last_r) begin
            n_edges++;
            if (cyc + 4 < MAXC) begin
                exp_q[cyc+3][4]   = 1'b1;
                exp_q[cyc+4][3:0] = exp_q[cyc+4][3:0] |
                    {n_edges % (1 << CW) == 0, n_edges % (1 << SL) == 0,
                     n_edges % (1 << FS) == 0, n_edges % (1 << DB) == 0};
            end
        end
        last_r = in_reset ? 1'b0 : r;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        o = observed();
        if (o[4]) begin cnt_sync++; last_sync_cyc = cyc; end
        if (o[3]) begin cnt_1hz++; hz_cyc.push_back(cyc); end
        if (o[2]) cnt_slow++;
        if (o[1]) cnt_fast++;
        if (o[0]) cnt_deb++;
        check_vec("cycle", o, (cyc < MAXC) ? exp_q[cyc] : 5'b0);
    endtask

    task automatic run_edges(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            repeat (rnd ? $urandom_range(1, 3) : 1) tick(1'b1);
            repeat (rnd ? $urandom_range(1, 3) : 1) tick(1'b0);
        end
    endtask

    task automatic flush();
        repeat (5) tick(1'b0);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        in_reset = 1'b1;
        #1;
        check_vec("reset_async", observed(), 5'b0);
        for (int i = cyc; i < cyc + 6 && i < MAXC; i++) exp_q[i] = 5'b0;
        n_edges = 0;
        repeat (hold) tick(~refclk);
        rst_n = 1'b1;
        in_reset = 1'b0;
        last_r = 1'b0;
    endtask

    initial begin
        int s, s1, sd, sf, ss, apply_cyc;
        for (int i = 0; i < MAXC; i++) exp_q[i] = 5'b0;

        @(negedge clk);
        do_reset(8);
        repeat (3) tick(1'b0);

        apply_cyc = cyc;
        tick(1'b1);
        repeat (5) tick(1'b1);
        check_int("sync_latency", last_sync_cyc - apply_cyc, 3);
        check_int("sync_single", cnt_sync, 1);
        flush();

        s = cnt_sync;
        run_edges(1000, 1'b0);
        flush();
        check_int("edge_count_clk_div2", cnt_sync - s, 1000);

        do_reset(4);
        s1 = cnt_1hz; sd = cnt_deb; sf = cnt_fast; ss = cnt_slow;
        hz_cyc.delete();
        run_edges(2 * (1 << CW), 1'b0);
        flush();
        check_int("onehz_count", cnt_1hz - s1, 2);
        check_int("debounce_count", cnt_deb - sd, 2 * (1 << (CW - DB)));
        check_int("fast_count", cnt_fast - sf, 2 * (1 << (CW - FS)));
        check_int("slow_count", cnt_slow - ss, 2 * (1 << (CW - SL)));
        if (hz_cyc.size() == 2)
            check_int("onehz_gap_cycles", hz_cyc[1] - hz_cyc[0], 2 * (1 << CW));
        else
            check_int("onehz_gap_samples", hz_cyc.size(), 2);

        run_edges(300, 1'b1);
        flush();

        run_edges(10, 1'b1);
        do_reset(5);
        sf = cnt_fast;
        run_edges((1 << FS) - 1, 1'b1);
        flush();
        check_int("midreset_no_early_fast", cnt_fast - sf, 0);
        run_edges(1, 1'b1);
        flush();
        check_int("midreset_fast_at_boundary", cnt_fast - sf, 1);

        run_edges(5, 1'b1);
        tick(1'b1);
        repeat (6) tick(1'b1);
        s = cnt_sync; sd = cnt_deb;
        repeat (10000) tick(1'b1);
        check_int("stall_no_sync", cnt_sync - s, 0);
        check_int("stall_no_strobe", cnt_deb - sd, 0);
        repeat (3) tick(1'b0);
        run_edges(8, 1'b1);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
